alu_seq_ctrl: RTL and testbench

- Sequencer for multi-cycle ALU operations (MUL, DIV, MOD, POW, RAD) that sits between the combinational control unit and the ALU.
- Generates the `ready` strobe that the control unit uses to gate PC load, register writes, flag saves and memory writes.
- Single-cycle ops pass straight through. Multi-cycle ops are started on the iterative unit, counted to completion, then released.
- Also merges the external memory wait into `ready`.

---
 rtl/alu_seq_ctrl.sv | 131 +++++++++++++
 tb/tb_alu_seq_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - multi-cycle ALU op sequencer and ready generator (optional macro SEQ_STALL_CNT_EN adds stall_cycles)
module alu_seq_ctrl #(
  parameter int         W       = 16,
  parameter logic [4:0] OP_MUL  = 5'd10,
  parameter logic [4:0] OP_DIV  = 5'd11,
  parameter logic [4:0] OP_MOD  = 5'd12,
  parameter logic [4:0] OP_POW  = 5'd13,
  parameter logic [4:0] OP_RAD  = 5'd14,
  parameter int         LAT_MUL = 4,
  parameter int         LAT_DIV = 16,
  parameter int         LAT_POW = 8,
  parameter int         LAT_RAD = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [4:0]   opsel,
  input  logic [W-1:0] operand_b,
  input  logic         mem_wait,
  output logic         start,
  output logic [4:0]   unit_op,
  output logic         busy,
  output logic         ready,
  output logic         div0
`ifdef SEQ_STALL_CNT_EN
  ,
  output logic [31:0]  stall_cycles
`endif
);

  localparam int MAX_MD  = (LAT_MUL > LAT_DIV) ? LAT_MUL : LAT_DIV;
  localparam int MAX_PR  = (LAT_POW > LAT_RAD) ? LAT_POW : LAT_RAD;
  localparam int MAX_LAT = (MAX_MD > MAX_PR) ? MAX_MD : MAX_PR;
  localparam int CW      = $clog2(MAX_LAT) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [4:0]    unit_op_nxt;
  logic          div0_lat, div0_lat_nxt;
  logic          is_multi, is_divmod, div_zero;
  logic [CW-1:0] lat_sel;

  // Decode the incoming op: multi-cycle membership, its latency, and divide-by-zero
  always_comb begin
    is_divmod = (opsel == OP_DIV) || (opsel == OP_MOD);
    is_multi  = (opsel == OP_MUL) || is_divmod || (opsel == OP_POW) || (opsel == OP_RAD);
    div_zero  = is_divmod && (operand_b == '0);
    lat_sel   = CW'(LAT_MUL);
    if (is_divmod)              lat_sel = CW'(LAT_DIV);
    else if (opsel == OP_POW)   lat_sel = CW'(LAT_POW);
    else if (opsel == OP_RAD)   lat_sel = CW'(LAT_RAD);
  end

  // Next-state logic and strobes; reset forces every strobe low, including the combinational ready
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    unit_op_nxt  = unit_op;
    div0_lat_nxt = div0_lat;
    start        = 1'b0;
    busy         = 1'b0;
    ready        = 1'b0;
    case (state)
      S_IDLE: begin
        if (is_multi) begin
          unit_op_nxt = opsel;
          if (div_zero) begin
            div0_lat_nxt = 1'b1;
            state_nxt    = S_DONE;
          end else begin
            start     = 1'b1;
            cnt_nxt   = lat_sel - 1'b1;
            state_nxt = S_BUSY;
          end
        end else begin
          ready = ~mem_wait;
        end
      end
      S_BUSY: begin
        busy    = 1'b1;
        cnt_nxt = cnt - 1'b1;
        if (cnt == CW'(1)) state_nxt = S_DONE;
      end
      S_DONE: begin
        ready = ~mem_wait;
        if (!mem_wait) begin
          state_nxt    = S_IDLE;
          div0_lat_nxt = 1'b0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (!rst) begin
      start = 1'b0;
      busy  = 1'b0;
      ready = 1'b0;
    end
  end

  assign div0 = div0_lat & ready;

  // Sequencer state, latency counter, op register and divide-by-zero latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      unit_op  <= 5'd0;
      div0_lat <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      unit_op  <= unit_op_nxt;
      div0_lat <= div0_lat_nxt;
    end
  end

`ifdef SEQ_STALL_CNT_EN
  // Saturating count of every cycle the instruction is held (ready low)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= 32'd0;
    end else if (!ready && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - scoreboard bench for alu_seq_ctrl with randomized instruction stream
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  opsel;
  logic [15:0] operand_b;
  logic        mem_wait;
  logic        start;
  logic [4:0]  unit_op;
  logic        busy;
  logic        ready;
  logic        div0;
`ifdef SEQ_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  alu_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .opsel     (opsel),
    .operand_b (operand_b),
    .mem_wait  (mem_wait),
    .start     (start),
    .unit_op   (unit_op),
    .busy      (busy),
    .ready     (ready),
    .div0      (div0)
`ifdef SEQ_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    bit         dz;
    int         starts;
    int         busy_n;
    logic [4:0] uop;
  } exp_t;

  exp_t       sbq[$];
  int         checks   = 0;
  int         failures = 0;
  logic [4:0] model_uop = 5'd0;
  longint     model_stall = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int lat_of(input logic [4:0] op);
    case (op)
      5'd10:         return 4;
      5'd11, 5'd12:  return 16;
      5'd13, 5'd14:  return 8;
      default:       return 0;
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    sbq.delete();
    model_uop   = 5'd0;
    model_stall = 0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Present one instruction, holding it until ready, with per-cycle mem_wait pattern pat
  task automatic run_instr(input logic [4:0] op, input logic [15:0] b, input logic [63:0] pat);
    exp_t e;
    int   lat, base, c;
    bit   mc, dz, done;
    lat  = lat_of(op);
    mc   = (lat != 0);
    dz   = mc && (op == 5'd11 || op == 5'd12) && (b == 16'd0);
    base = !mc ? 0 : (dz ? 1 : lat);
    c    = base;
    while (c < 64 && pat[c]) c++;
    if (mc) model_uop = op;
    e.cyc    = c;
    e.dz     = dz;
    e.starts = (mc && !dz) ? 1 : 0;
    e.busy_n = (mc && !dz) ? lat - 1 : 0;
    e.uop    = model_uop;
    model_stall += c;
    sbq.push_back(e);
    c    = 0;
    done = 0;
    while (!done) begin
      opsel     = op;
      operand_b = b;
      mem_wait  = (c < 64) ? pat[c] : 1'b0;
      @(negedge clk);
      if (ready) begin
        done = 1;
      end else if (c >= 90) begin
        checks++;
        failures++;
        $display("FAIL timeout_waiting_ready actual=0 required=1");
        @(posedge clk);
        #1;
        do_reset();
        return;
      end
      @(posedge clk);
      #1;
      c++;
    end
  endtask

  // Monitor: counts cycles, starts and busy since the last ready, compares on each ready
  initial begin
    int   cyc = 0, nst = 0, nbz = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        cyc = 0; nst = 0; nbz = 0;
      end else begin
        if (start) nst++;
        if (busy)  nbz++;
        if (div0 && !ready) chk("div0_without_ready", div0, 0);
        if (ready) begin
          if (sbq.size() == 0) begin
            chk("unexpected_ready", 1, 0);
          end else begin
            e = sbq.pop_front();
            chk("ready_cycle", cyc, e.cyc);
            chk("div0", div0, e.dz);
            chk("start_count", nst, e.starts);
            chk("busy_cycles", nbz, e.busy_n);
            chk("unit_op", unit_op, e.uop);
          end
          cyc = 0; nst = 0; nbz = 0;
        end else begin
          cyc++;
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] pat;
    logic [4:0]  op;
    logic [15:0] b;
    rst = 1'b0; opsel = 5'd0; operand_b = 16'd0; mem_wait = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready_forced_low", ready, 0);
    chk("rst_div0", div0, 0);
    chk("rst_unit_op", unit_op, 0);
    opsel = 5'd10; operand_b = 16'd3;
    #1;
    chk("rst_start_multi", start, 0);
    opsel = 5'd0;
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Directed: ADD, MUL, DIV by zero, POW with memory wait in cycles 6..10
    run_instr(5'd0, 16'd7, 64'd0);
    run_instr(5'd10, 16'd3, 64'd0);
    run_instr(5'd11, 16'd0, 64'd0);
    run_instr(5'd1, 16'd0, 64'd0);
    pat = 64'd0;
    for (int i = 6; i <= 10; i++) pat[i] = 1'b1;
    run_instr(5'd13, 16'd9, pat);

    // Directed: reset in the middle of a divide
    opsel = 5'd11; operand_b = 16'd5; mem_wait = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("busy_before_reset", busy, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", ready, 0);
    chk("midrst_start", start, 0);
    chk("midrst_unit_op", unit_op, 0);
    model_uop   = 5'd0;
    model_stall = 0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    run_instr(5'd11, 16'd5, 64'd0);

    // Randomized instruction stream
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 1) == 1) op = 5'(10 + $urandom_range(0, 4));
      else                           op = 5'($urandom_range(0, 31));
      b   = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
      pat = 64'd0;
      if ($urandom_range(0, 2) != 0) begin
        for (int i = 0; i < 30; i++) pat[i] = ($urandom_range(0, 3) == 0);
      end
      run_instr(op, b, pat);
    end

`ifdef SEQ_STALL_CNT_EN
    chk("stall_cycles", stall_cycles, model_stall);
`endif
    chk("scoreboard_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
